// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin share of one pmem line port between I-cache and D-cache (optional prefetch port via PMEM_PREFETCH_PORT_EN)
module pmem_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int LINE_W         = 128,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef PMEM_PREFETCH_PORT_EN
   input  logic              pf_pmem_read,
   input  logic [ADDR_W-1:0] pf_pmem_address,
   output logic              pf_pmem_resp,
   output logic              l1_lockout,
`endif
   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_address,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic              d_pmem_resp,
   output logic [LINE_W-1:0] pmem_rdata_out,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              err_timeout
);
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_PRE = WDOG_W'(TIMEOUT_CYCLES - 1);
   typedef enum logic [1:0] {
      IDLE,
      GNT_I,
`ifdef PMEM_PREFETCH_PORT_EN
      GNT_P,
`endif
      GNT_D
   } state_t;
   state_t state, state_nxt;
   logic last_d;
   logic [WDOG_W-1:0] wdog;
   logic pend_i, pend_d;
   assign pend_i = i_pmem_read;
   assign pend_d = d_pmem_read | d_pmem_write;
   assign pmem_rdata_out = pmem_rdata;
   // state register and round-robin memory; last only tracks I/D grants
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_d <= 1'b1;
      end else begin
         state  <= state_nxt;
         if (state == IDLE && state_nxt == GNT_I) last_d <= 1'b0;
         if (state == IDLE && state_nxt == GNT_D) last_d <= 1'b1;
      end
   end
   // grant watchdog: counts unanswered grant cycles, flags once it reaches the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog        <= '0;
         err_timeout <= 1'b0;
      end else if (state == IDLE) begin
         wdog <= '0;
      end else if (!pmem_resp && wdog != WDOG_MAX) begin
         wdog <= wdog + WDOG_W'(1);
         if (wdog == WDOG_PRE) err_timeout <= 1'b1;
      end
   end
   // next-state and owner-routed pmem command / response decode
   always_comb begin
      state_nxt    = state;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
`ifdef PMEM_PREFETCH_PORT_EN
      pf_pmem_resp = 1'b0;
      l1_lockout   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pend_i && (!pend_d || last_d)) state_nxt = GNT_I;
            else if (pend_d) state_nxt = GNT_D;
`ifdef PMEM_PREFETCH_PORT_EN
            else if (pf_pmem_read) state_nxt = GNT_P;
`endif
         end
         GNT_I: begin
            pmem_read    = i_pmem_read;
            pmem_address = i_pmem_address;
            i_pmem_resp  = pmem_resp;
            if (pmem_resp || !pend_i) state_nxt = IDLE;
         end
         GNT_D: begin
            pmem_write   = d_pmem_write;
            pmem_read    = d_pmem_read & ~d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
            d_pmem_resp  = pmem_resp;
            if (pmem_resp || !pend_d) state_nxt = IDLE;
         end
`ifdef PMEM_PREFETCH_PORT_EN
         GNT_P: begin
            pmem_read    = pf_pmem_read;
            pmem_address = pf_pmem_address;
            pf_pmem_resp = pmem_resp;
            l1_lockout   = 1'b1;
            if (pmem_resp || !pf_pmem_read) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed self-checking bench for pmem_arbiter (TIMEOUT_CYCLES=8)
module tb_pmem_arbiter;
   localparam int AW = 16;
   localparam int LW = 128;
   logic clk = 1'b0;
   logic rst_n;
   logic i_pmem_read, i_pmem_resp;
   logic [AW-1:0] i_pmem_address;
   logic d_pmem_read, d_pmem_write, d_pmem_resp;
   logic [AW-1:0] d_pmem_address;
   logic [LW-1:0] d_pmem_wdata, pmem_rdata_out, pmem_wdata, pmem_rdata;
   logic pmem_read, pmem_write, pmem_resp, err_timeout;
   logic [AW-1:0] pmem_address;
`ifdef PMEM_PREFETCH_PORT_EN
   logic pf_pmem_read = 1'b0;
   logic [AW-1:0] pf_pmem_address = '0;
   logic pf_pmem_resp, l1_lockout;
`endif
   int checks = 0;
   int errors = 0;
   localparam logic [LW-1:0] WD = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
   localparam logic [LW-1:0] RD = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

   pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef PMEM_PREFETCH_PORT_EN
      .pf_pmem_read(pf_pmem_read), .pf_pmem_address(pf_pmem_address),
      .pf_pmem_resp(pf_pmem_resp), .l1_lockout(l1_lockout),
`endif
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write), .d_pmem_address(d_pmem_address),
      .d_pmem_wdata(d_pmem_wdata), .d_pmem_resp(d_pmem_resp), .pmem_rdata_out(pmem_rdata_out),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // in a grant cycle: check the command, answer it, then check the bubble that follows
   task automatic serve(input string tag, input logic [AW-1:0] addr, input logic to_i);
      chk({tag, " read"}, LW'(pmem_read), LW'(1));
      chk({tag, " addr"}, LW'(pmem_address), LW'(addr));
      pmem_resp = 1'b1;
      #1;
      chk({tag, " i_resp"}, LW'(i_pmem_resp), LW'(to_i));
      chk({tag, " d_resp"}, LW'(d_pmem_resp), LW'(!to_i));
      tick;
      pmem_resp = 1'b0;
      #1;
      chk({tag, " bubble read"}, LW'(pmem_read), LW'(0));
      chk({tag, " bubble resp"}, LW'(i_pmem_resp | d_pmem_resp), LW'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      {i_pmem_read, d_pmem_read, d_pmem_write, pmem_resp} = '0;
      i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0; pmem_rdata = '0;
      tick;
      chk("rst read", LW'(pmem_read), LW'(0));
      chk("rst write", LW'(pmem_write), LW'(0));
      chk("rst addr", LW'(pmem_address), LW'(0));
      chk("rst err", LW'(err_timeout), LW'(0));
      rst_n = 1'b1;
      tick;
      // lone I read
      i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
      #1;
      chk("i idle no cmd", LW'(pmem_read), LW'(0));
      tick;
      chk("i cmd", LW'(pmem_read), LW'(1));
      chk("i addr", LW'(pmem_address), LW'(16'h1230));
      chk("i no early resp", LW'(i_pmem_resp), LW'(0));
      tick; tick;
      pmem_resp = 1'b1; pmem_rdata = RD;
      #1;
      chk("i resp", LW'(i_pmem_resp), LW'(1));
      chk("i d_resp", LW'(d_pmem_resp), LW'(0));
      chk("rdata bcast", pmem_rdata_out, RD);
      tick;
      i_pmem_read = 1'b0; pmem_resp = 1'b0;
      #1;
      chk("i after idle", LW'(pmem_read), LW'(0));
      chk("i resp one cycle", LW'(i_pmem_resp), LW'(0));
      // round robin from fresh reset
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
      d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
      tick;
      serve("rr1 I", 16'h1000, 1'b1);
      tick;
      serve("rr2 D", 16'h2000, 1'b0);
      tick;
      serve("rr3 I", 16'h1000, 1'b1);
      tick;
      serve("rr4 D", 16'h2000, 1'b0);
      i_pmem_read = 1'b0; d_pmem_read = 1'b0;
      tick;
      // D write-back (with illegal read+write), I waits, then D fetch
      d_pmem_write = 1'b1; d_pmem_read = 1'b1; d_pmem_address = 16'h4000; d_pmem_wdata = WD;
      tick;
      chk("wb write", LW'(pmem_write), LW'(1));
      chk("wb read suppressed", LW'(pmem_read), LW'(0));
      chk("wb addr", LW'(pmem_address), LW'(16'h4000));
      chk("wb wdata", pmem_wdata, WD);
      i_pmem_read = 1'b1; i_pmem_address = 16'h1240;
      pmem_resp = 1'b1;
      #1;
      chk("wb d_resp", LW'(d_pmem_resp), LW'(1));
      chk("wb i_resp", LW'(i_pmem_resp), LW'(0));
      tick;
      pmem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
      #1;
      chk("wb bubble write", LW'(pmem_write), LW'(0));
      chk("wb bubble read", LW'(pmem_read), LW'(0));
      chk("wb bubble wdata", pmem_wdata, LW'(0));
      tick;
      serve("split I", 16'h1240, 1'b1);
      i_pmem_read = 1'b0;
      tick;
      chk("fetch write", LW'(pmem_write), LW'(0));
      serve("fetch D", 16'h4000, 1'b0);
      d_pmem_read = 1'b0;
      tick;
      // async reset in the middle of a D write
      d_pmem_write = 1'b1; d_pmem_address = 16'h5000; d_pmem_wdata = WD;
      tick;
      chk("rw write", LW'(pmem_write), LW'(1));
      rst_n = 1'b0; pmem_resp = 1'b1;
      #1;
      chk("rw async drop", LW'(pmem_write), LW'(0));
      chk("rw no resp", LW'(d_pmem_resp), LW'(0));
      tick; tick;
      rst_n = 1'b1; d_pmem_write = 1'b0; pmem_resp = 1'b0;
      #1;
      chk("rw err", LW'(err_timeout), LW'(0));
      tick;
      chk("rw idle", LW'(pmem_write | pmem_read), LW'(0));
      // owner withdraws before resp; late pmem_resp in IDLE is ignored
      i_pmem_read = 1'b1; i_pmem_address = 16'h7770;
      tick;
      chk("wd grant", LW'(pmem_read), LW'(1));
      i_pmem_read = 1'b0;
      tick;
      pmem_resp = 1'b1;
      #1;
      chk("wd idle resp ignored", LW'(i_pmem_resp | d_pmem_resp), LW'(0));
      chk("wd no err", LW'(err_timeout), LW'(0));
      pmem_resp = 1'b0;
      tick;
      // watchdog: 12 silent grant cycles, then a late resp
      i_pmem_read = 1'b1; i_pmem_address = 16'h8880;
      tick;
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("to pre %0d", k), LW'(err_timeout), LW'(0));
         tick;
      end
      chk("to set", LW'(err_timeout), LW'(1));
      chk("to still granted", LW'(pmem_read), LW'(1));
      tick; tick; tick; tick;
      pmem_resp = 1'b1;
      #1;
      chk("to late resp", LW'(i_pmem_resp), LW'(1));
      tick;
      pmem_resp = 1'b0; i_pmem_read = 1'b0;
      #1;
      chk("to sticky", LW'(err_timeout), LW'(1));
      chk("to idle", LW'(pmem_read), LW'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
